// File: rtl/vga_timing_gen.sv
// Free-running VGA raster generator: pixel counters, delayed hs/vs/blank,
// an undelayed frame_start strobe and a completed-frame counter.
module vga_timing_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int SYNC_ACTIVE = 0,
  parameter int PIPE_DELAY  = 1
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START  = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START  = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic       SYNC_ON = (SYNC_ACTIVE != 0);
  // Packed as {hs, vs, blank}; the idle value is sync deasserted, blank off.
  localparam logic [2:0] IDLE    = {~SYNC_ON, ~SYNC_ON, 1'b0};

  if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if ((PIPE_DELAY < 0) || (PIPE_DELAY > 3)) begin : g_bad_delay
    $error("vga_timing_gen: PIPE_DELAY must be within 0..3");
  end

  logic [9:0]  hc_reg, vc_reg, hc_next, vc_next;
  logic [10:0] hc_ext, vc_ext;
  logic        h_wrap, v_wrap;
  logic        frame_start_reg;
  logic [15:0] frame_count_reg;
  logic [2:0]  raw_vec, out_vec;

  always_comb begin
    hc_ext  = {1'b0, hc_reg};
    vc_ext  = {1'b0, vc_reg};
    h_wrap  = (hc_ext == H_LAST);
    v_wrap  = (vc_ext == V_LAST);
    hc_next = h_wrap ? 10'd0 : hc_reg + 10'd1;
    vc_next = vc_reg;
    if (h_wrap) begin
      vc_next = v_wrap ? 10'd0 : vc_reg + 10'd1;
    end
    raw_vec[2] = ((hc_ext >= HS_START) && (hc_ext < HS_END)) ? SYNC_ON : ~SYNC_ON;
    raw_vec[1] = ((vc_ext >= VS_START) && (vc_ext < VS_END)) ? SYNC_ON : ~SYNC_ON;
    raw_vec[0] = (hc_ext < H_VIS_END) && (vc_ext < V_VIS_END);
  end

  // frame_start is registered from the next position, so the (0,0) held
  // during reset never produces a strobe.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      hc_reg          <= '0;
      vc_reg          <= '0;
      frame_start_reg <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      hc_reg          <= hc_next;
      vc_reg          <= vc_next;
      frame_start_reg <= (hc_next == 10'd0) && (vc_next == 10'd0);
      if (h_wrap && v_wrap) begin
        frame_count_reg <= frame_count_reg + 16'd1;
      end
    end
  end

  if (PIPE_DELAY == 0) begin : g_comb
    // Without a delay chain, a flag masks the raw terms while reset is in force.
    logic in_reset_reg;
    always_ff @(posedge vga_clk) begin
      in_reset_reg <= ~reset_n;
    end
    assign out_vec = in_reset_reg ? IDLE : raw_vec;
  end else begin : g_pipe
    logic [2:0] pipe_reg [PIPE_DELAY];
    always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
        for (int i = 0; i < PIPE_DELAY; i++) begin
          pipe_reg[i] <= IDLE;
        end
      end else begin
        pipe_reg[0] <= raw_vec;
        for (int i = 1; i < PIPE_DELAY; i++) begin
          pipe_reg[i] <= pipe_reg[i-1];
        end
      end
    end
    assign out_vec = pipe_reg[PIPE_DELAY-1];
  end

  assign DrawX       = hc_reg;
  assign DrawY       = vc_reg;
  assign hs          = out_vec[2];
  assign vs          = out_vec[1];
  assign blank       = out_vec[0];
  assign frame_start = frame_start_reg;
  assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full 640x480 line timing (delays 1 and 3) plus small-raster
// instances for frame, blank-region, polarity, mid-frame reset and counter wrap.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic [9:0]  x_a, y_a, x_b, y_b, x_c, y_c, x_d, y_d;
  logic        hs_a, vs_a, blank_a, fs_a;
  logic        hs_b, vs_b, blank_b, fs_b;
  logic        hs_c, vs_c, blank_c, fs_c;
  logic        hs_d, vs_d, blank_d, fs_d;
  logic [15:0] fc_a, fc_b, fc_c, fc_d;

  // a: default geometry, delay 1, active-low sync
  vga_timing_gen dut_a (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(x_a), .DrawY(y_a),
    .hs(hs_a), .vs(vs_a), .blank(blank_a), .frame_start(fs_a), .frame_count(fc_a)
  );

  // b: 15x11 raster (hsync x=10..12, vsync y=7..8, visible 8x6), delay 1
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .SYNC_ACTIVE(0), .PIPE_DELAY(1)
  ) dut_b (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(x_b), .DrawY(y_b),
    .hs(hs_b), .vs(vs_b), .blank(blank_b), .frame_start(fs_b), .frame_count(fc_b)
  );

  // c: same small raster, no delay, active-high sync
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .SYNC_ACTIVE(1), .PIPE_DELAY(0)
  ) dut_c (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(x_c), .DrawY(y_c),
    .hs(hs_c), .vs(vs_c), .blank(blank_c), .frame_start(fs_c), .frame_count(fc_c)
  );

  // d: default geometry, delay 3
  vga_timing_gen #(.PIPE_DELAY(3)) dut_d (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(x_d), .DrawY(y_d),
    .hs(hs_d), .vs(vs_d), .blank(blank_d), .frame_start(fs_d), .frame_count(fc_d)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  int seq_bad_a, hs_low_a, first_hs_a, blank_hi_a;
  logic blank_a_640, blank_a_641;
  int hs_low_d, first_hs_d, first_blank_d, fall_blank_d;
  int fs_cnt_b, first_fs_b, vs_low_b, first_vs_b, hs_low_b, region_bad_b;
  logic [15:0] fc_b_164, fc_b_165, fc_b_330;
  logic b83, b84;
  int hs_hi_c, first_hs_c, vs_hi_c, first_vs_c;
  logic c7, c8;
  int rst_bad, wait_cnt;

  initial begin
    seq_bad_a = 0; hs_low_a = 0; first_hs_a = 0; blank_hi_a = 0;
    hs_low_d = 0; first_hs_d = 0; first_blank_d = 0; fall_blank_d = 0;
    fs_cnt_b = 0; first_fs_b = 0; vs_low_b = 0; first_vs_b = 0; hs_low_b = 0; region_bad_b = 0;
    hs_hi_c = 0; first_hs_c = 0; vs_hi_c = 0; first_vs_c = 0;
    rst_bad = 0;

    // Reset state
    reset_n = 1'b0;
    repeat (3) step();
    check("rst_drawx_a", x_a, 0);
    check("rst_drawy_a", y_a, 0);
    check("rst_hs_a", hs_a, 1);
    check("rst_vs_a", vs_a, 1);
    check("rst_blank_a", blank_a, 0);
    check("rst_fs_a", fs_a, 0);
    check("rst_fc_a", fc_a, 0);
    check("rst_hs_c", hs_c, 0);
    check("rst_vs_c", vs_c, 0);
    check("rst_blank_c", blank_c, 0);
    check("rst_hs_d", hs_d, 1);
    check("rst_blank_d", blank_d, 0);
    $display("reset state checked");

    // 800 cycles after release: one full default line
    reset_n = 1'b1;
    for (int k = 1; k <= 800; k++) begin
      step();
      if ((x_a !== 10'(k % 800)) || (y_a !== 10'(k / 800))) seq_bad_a++;
      if (hs_a == 1'b0) begin hs_low_a++; if (first_hs_a == 0) first_hs_a = k; end
      if (blank_a) blank_hi_a++;
      if (k == 640) blank_a_640 = blank_a;
      if (k == 641) blank_a_641 = blank_a;

      if (hs_d == 1'b0) begin hs_low_d++; if (first_hs_d == 0) first_hs_d = k; end
      if (blank_d && first_blank_d == 0) first_blank_d = k;
      if (!blank_d && first_blank_d != 0 && fall_blank_d == 0) fall_blank_d = k;

      if (fs_b) begin fs_cnt_b++; if (first_fs_b == 0) first_fs_b = k; end
      if (k == 164) fc_b_164 = fc_b;
      if (k == 165) fc_b_165 = fc_b;
      if (k == 330) fc_b_330 = fc_b;
      if (vs_b == 1'b0) begin vs_low_b++; if (first_vs_b == 0) first_vs_b = k; end
      if (hs_b == 1'b0) hs_low_b++;
      if ((((k - 1) % 165) / 15) >= 6 && blank_b) region_bad_b++;
      if (k == 83) b83 = blank_b;
      if (k == 84) b84 = blank_b;

      if (hs_c) begin hs_hi_c++; if (first_hs_c == 0) first_hs_c = k; end
      if (vs_c) begin vs_hi_c++; if (first_vs_c == 0) first_vs_c = k; end
      if (k == 7) c7 = blank_c;
      if (k == 8) c8 = blank_c;
    end

    check("a_draw_sequence", seq_bad_a, 0);
    check("a_drawx_wrap", x_a, 0);
    check("a_drawy_wrap", y_a, 1);
    check("a_hs_width", hs_low_a, 96);
    check("a_hs_first", first_hs_a, 657);
    check("a_blank_width", blank_hi_a, 640);
    check("a_blank_x639", blank_a_640, 1);
    check("a_blank_x640", blank_a_641, 0);
    $display("line on default raster checked (delay 1)");

    check("d_hs_width", hs_low_d, 96);
    check("d_hs_first", first_hs_d, 659);
    check("d_blank_rise", first_blank_d, 3);
    check("d_blank_fall", fall_blank_d, 643);
    $display("line on default raster checked (delay 3)");

    check("b_fs_count", fs_cnt_b, 4);
    check("b_fs_first", first_fs_b, 165);
    check("b_fc_before", fc_b_164, 0);
    check("b_fc_frame1", fc_b_165, 1);
    check("b_fc_frame2", fc_b_330, 2);
    check("b_vs_total", vs_low_b, 150);
    check("b_vs_first", first_vs_b, 106);
    check("b_hs_total", hs_low_b, 159);
    check("b_blank_region", region_bad_b, 0);
    check("b_blank_last_vis", b83, 1);
    check("b_blank_after_vis", b84, 0);
    $display("frames on small raster checked (delay 1)");

    check("c_hs_total", hs_hi_c, 159);
    check("c_hs_first", first_hs_c, 10);
    check("c_vs_total", vs_hi_c, 150);
    check("c_vs_first", first_vs_c, 105);
    check("c_blank_x7", c7, 1);
    check("c_blank_x8", c8, 0);
    $display("frames on small raster checked (delay 0, active-high sync)");

    // Mid-frame reset inside hsync of the small raster
    wait_cnt = 0;
    while (!((x_b == 10'd11) && (y_b == 10'd3)) && wait_cnt < 300) begin
      step();
      wait_cnt++;
    end
    check("b_reach_hsync", ((x_b == 10'd11) && (y_b == 10'd3)), 1);
    check("b_hs_in_sync", hs_b, 0);
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if ((hs_b !== 1'b1) || (vs_b !== 1'b1) || (blank_b !== 1'b0) || (x_b !== 10'd0) ||
          (y_b !== 10'd0) || (fc_b !== 16'd0) || (fs_b !== 1'b0) || (hs_c !== 1'b0)) rst_bad++;
    end
    check("b_mid_reset_hold", rst_bad, 0);
    check("b_mid_reset_hs", hs_b, 1);
    check("b_mid_reset_fc", fc_b, 0);
    check("d_mid_reset_hs", hs_d, 1);
    reset_n = 1'b1;
    step();
    check("b_release_x1", x_b, 1);
    step();
    check("b_release_x2", x_b, 2);
    check("a_release_x2", x_a, 2);
    step();
    check("b_release_x3", x_b, 3);
    check("b_release_y", y_b, 0);
    $display("mid-frame reset checked");

    // frame_count wrap from 65535
    wait_cnt = 0;
    while (!((x_b == 10'd14) && (y_b == 10'd10)) && wait_cnt < 400) begin
      step();
      wait_cnt++;
    end
    check("b_reach_frame_end", ((x_b == 10'd14) && (y_b == 10'd10)), 1);
    force dut_b.frame_count_reg = 16'hFFFF;
    #1;
    release dut_b.frame_count_reg;
    #1;
    check("b_fc_preload", fc_b, 16'hFFFF);
    check("b_fs_before_wrap", fs_b, 0);
    step();
    check("b_fc_wrap", fc_b, 0);
    check("b_fs_at_wrap", fs_b, 1);
    check("b_x_at_wrap", x_b, 0);
    check("b_y_at_wrap", y_b, 0);
    step();
    check("b_fs_one_cycle", fs_b, 0);
    check("b_fc_hold", fc_b, 0);
    $display("frame_count wrap checked");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
